// File: rtl/id_issue_queue_pkg.sv
// Shared definitions for the ID issue queue: instruction field positions,
// the IF->ID entry layout, and the forward-port bundle width.
package id_issue_queue_pkg;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int REG_ZERO = 0;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

  // One forwarding port carries {we, pend, waddr, wdata}.
  function automatic int fwd_bundle_w(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

endpackage

// File: rtl/id_issue_queue_fwd_resolve.sv
// Resolves one source operand against prioritised forwarding ports.
// Port 0 is the youngest producer and wins over higher-index ports.
module id_fwd_resolve
  import id_issue_queue_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int AW      = 5
) (
  input  logic [AW-1:0]             addr,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_pend,
  input  logic [NUM_FWD*AW-1:0]     fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic [DATA_W-1:0]         data,
  output logic                      hazard
);

  logic found;

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    if (addr == AW'(REG_ZERO)) begin
      data = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
          found = 1'b1;
          if (fwd_pend[i]) hazard = 1'b1;
          else             data   = fwd_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_queue.sv
// Decode-stage instruction queue: buffers fetched {pc, inst}, resolves rs/rt
// for the head entry via regfile + forwarding, and issues to EX on valid/ready.
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int AW      = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PC_W-1:0]               in_pc,
  input  logic [INST_W-1:0]             in_inst,
  output logic [AW-1:0]                 rf_raddr1,
  output logic [AW-1:0]                 rf_raddr2,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD-1:0]            fwd_pend,
  input  logic [NUM_FWD*AW-1:0]         fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_W-1:0]               out_pc,
  output logic [INST_W-1:0]             out_inst,
  output logic [DATA_W-1:0]             out_rdata1,
  output logic [DATA_W-1:0]             out_rdata2,
  output logic                          stallreq,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [15:0]                   stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if_id_t            mem_q [DEPTH];
  if_id_t            mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              not_empty, push, pop, hazard, haz1, haz2;
  if_id_t            head;

  assign not_empty = (count_q != '0);
  // Zeroing the head when empty also forces both addresses to $0, so the
  // resolved operands read as 0 and no hazard can be raised.
  assign head      = not_empty ? mem_q[rd_ptr_q] : '0;

  assign rf_raddr1 = AW'(head.inst[RS_MSB:RS_LSB]);
  assign rf_raddr2 = AW'(head.inst[RT_MSB:RT_LSB]);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  id_fwd_resolve #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .AW(AW)) u_rs (
    .addr(rf_raddr1), .rf_data(rf_rdata1),
    .fwd_we(fwd_we), .fwd_pend(fwd_pend), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .data(out_rdata1), .hazard(haz1)
  );

  id_fwd_resolve #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .AW(AW)) u_rt (
    .addr(rf_raddr2), .rf_data(rf_rdata2),
    .fwd_we(fwd_we), .fwd_pend(fwd_pend), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .data(out_rdata2), .hazard(haz2)
  );

  assign hazard    = haz1 | haz2;
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = not_empty & ~hazard & ~flush;
  assign stallreq  = not_empty & hazard;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_pc, in_inst};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stallreq && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: ordering, forwarding priority, interlock,
// $0 handling, flush and asynchronous reset, with hand-computed expectations.
module tb_id_issue_queue;

  localparam int DEPTH = 4, NUM_FWD = 3, DATA_W = 32, AW = 5;

  logic                      clk = 1'b0;
  logic                      rst, flush, in_valid, out_ready;
  logic                      in_ready, out_valid, stallreq;
  logic [31:0]               in_pc, in_inst, out_pc, out_inst;
  logic [AW-1:0]             rf_raddr1, rf_raddr2;
  logic [DATA_W-1:0]         rf_rdata1, rf_rdata2, out_rdata1, out_rdata2;
  logic [NUM_FWD-1:0]        fwd_we, fwd_pend;
  logic [NUM_FWD*AW-1:0]     fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic [2:0]                count;
  logic [15:0]               stall_cnt;

  int checks = 0;
  int errors = 0;

  id_issue_queue #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_pend(fwd_pend), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .stallreq(stallreq), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0000};
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clr_fwd();
    fwd_we    = '0;
    fwd_pend  = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
    clr_fwd();

    #2;
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stallreq",  32'(stallreq),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_out_rdata1", out_rdata1,    32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;

    // Fill, reject when full (even with simultaneous pop), drain in order
    push(32'h100, mk(5'd1, 5'd2));
    push(32'h104, mk(5'd1, 5'd2));
    push(32'h108, mk(5'd1, 5'd2));
    push(32'h10C, mk(5'd1, 5'd2));
    #1;
    check("full_count",    32'(count),     32'd4);
    check("full_in_ready", 32'(in_ready),  32'd0);
    check("full_valid",    32'(out_valid), 32'd1);
    check("head0_pc",      out_pc,         32'h100);
    in_valid = 1'b1; in_pc = 32'h110; in_inst = mk(5'd1, 5'd2); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    check("head1_pc", out_pc, 32'h104);
    tick();
    check("head2_pc", out_pc, 32'h108);
    tick();
    check("head3_pc", out_pc, 32'h10C);
    tick();
    out_ready = 1'b0;
    check("drained_count", 32'(count),     32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Forwarding priority on rs=$3
    push(32'h200, mk(5'd3, 5'd2));
    fwd_we = 3'b101;
    fwd_waddr[0*AW +: AW] = 5'd3; fwd_wdata[0*DATA_W +: DATA_W] = 32'hAA;
    fwd_waddr[2*AW +: AW] = 5'd3; fwd_wdata[2*DATA_W +: DATA_W] = 32'hBB;
    #1;
    check("raddr1", 32'(rf_raddr1), 32'd3);
    check("raddr2", 32'(rf_raddr2), 32'd2);
    check("fwd_p0", out_rdata1, 32'hAA);
    check("fwd_rt_rf", out_rdata2, 32'h22);
    fwd_we = 3'b100;
    #1;
    check("fwd_p2", out_rdata1, 32'hBB);
    fwd_we = 3'b000;
    #1;
    check("fwd_none", out_rdata1, 32'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    clr_fwd();

    // Load-use interlock on rt=$5
    push(32'h300, mk(5'd1, 5'd5));
    fwd_we = 3'b001; fwd_pend = 3'b001; fwd_waddr[0*AW +: AW] = 5'd5;
    #1;
    check("haz_valid",    32'(out_valid), 32'd0);
    check("haz_stallreq", 32'(stallreq),  32'd1);
    tick(); tick(); tick();
    check("haz_stall_cnt", 32'(stall_cnt), 32'd3);
    clr_fwd();
    fwd_we = 3'b010; fwd_waddr[1*AW +: AW] = 5'd5; fwd_wdata[1*DATA_W +: DATA_W] = 32'h55;
    #1;
    check("haz_clear_rdata2", out_rdata2, 32'h55);
    check("haz_clear_valid",  32'(out_valid), 32'd1);
    check("haz_clear_stall",  32'(stallreq),  32'd0);
    fwd_we = 3'b011; fwd_pend = 3'b010;
    fwd_waddr[0*AW +: AW] = 5'd5; fwd_wdata[0*DATA_W +: DATA_W] = 32'h66;
    #1;
    check("mask_rdata2", out_rdata2, 32'h66);
    check("mask_stall",  32'(stallreq), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    clr_fwd();
    check("haz_pop_count", 32'(count), 32'd0);

    // Pending producer on $0 never stalls
    push(32'h400, mk(5'd0, 5'd2));
    fwd_we = 3'b001; fwd_pend = 3'b001; fwd_waddr[0*AW +: AW] = 5'd0;
    #1;
    check("zero_rdata1", out_rdata1, 32'd0);
    check("zero_valid",  32'(out_valid), 32'd1);
    check("zero_stall",  32'(stallreq),  32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    clr_fwd();

    // Flush with a simultaneous push
    push(32'h500, mk(5'd1, 5'd2));
    push(32'h504, mk(5'd1, 5'd2));
    push(32'h508, mk(5'd1, 5'd2));
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h50C; in_inst = mk(5'd1, 5'd2); out_ready = 1'b1;
    #1;
    check("flush_valid",    32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready),  32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("post_flush_count", 32'(count),     32'd0);
    check("post_flush_valid", 32'(out_valid), 32'd0);
    check("post_flush_stcnt", 32'(stall_cnt), 32'd3);

    // Asynchronous reset while stalled
    push(32'h600, mk(5'd1, 5'd5));
    push(32'h604, mk(5'd1, 5'd2));
    fwd_we = 3'b001; fwd_pend = 3'b001; fwd_waddr[0*AW +: AW] = 5'd5;
    #1;
    check("pre_rst_count", 32'(count),    32'd2);
    check("pre_rst_stall", 32'(stallreq), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",     32'(count),     32'd0);
    check("arst_valid",     32'(out_valid), 32'd0);
    check("arst_stallreq",  32'(stallreq),  32'd0);
    check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    #3;
    rst = 1'b0;
    clr_fwd();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
